// File: rtl/multi_cycle_control_unit.sv
// ---------------------------------------------------------------------------
// multi_cycle_control_unit
// Main control FSM of the multi-cycle RV32I core. It steps each instruction
// through IF/ID/EX/MEM/WB and drives the shared ALU, the memory port, the
// IR/PC load enables and the register-file write.
//
// Ports
//   clk, reset_n              : core clock (rising edge), async active-low reset
//   opcode                    : IR[6:0], valid from ID onward
//   bcond                     : ALU branch condition, used in EX for BRANCH
//   is_halt_ecall             : x17==10, sampled in ID for ECALL
//   mem_ready                 : memory access completes this cycle
//   pc_write, ir_write        : PC / IR+old_pc load enables
//   i_or_d                    : memory address select (0=PC, 1=ALUOut)
//   mem_read, mem_write       : memory requests
//   reg_write, wb_sel         : register-file write enable and rd data select
//   alu_src_a, alu_src_b      : ALU operand mux selects
//   alu_ctrl_op               : ALU-op class to alu_control_unit
//   pc_source                 : PC input select (0=ALU result, 1=ALUOut)
//   retire                    : one-cycle pulse when an instruction completes
//   is_halted, mem_err        : halt status and memory-timeout cause
// ---------------------------------------------------------------------------
module multi_cycle_control_unit #(
    parameter int MEM_WAIT_MAX = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       is_halt_ecall,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_ctrl_op,
    output logic       pc_source,
    output logic       retire,
    output logic       is_halted,
    output logic       mem_err
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);
    localparam logic       TIMEOUT_EN = (MEM_WAIT_MAX != 0) ? 1'b1 : 1'b0;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_wait_cnt;
    logic       r_mem_err;
    logic       w_set_err;
    logic       w_timeout;
    logic       w_waiting;

    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_i_or_d;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_reg_write;
    logic [1:0] w_wb_sel;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_ctrl_op;
    logic       w_pc_source;
    logic       w_retire;
    logic       w_is_halted;
    logic       w_mem_err;

    // A completing access wins over the timeout in the same cycle.
    assign w_timeout = TIMEOUT_EN & (r_wait_cnt == WAIT_LIMIT) & ~mem_ready;
    assign w_waiting = ((r_state == S_IF) || (r_state == S_MEM)) & ~mem_ready;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Wait counter: cleared on any state change, saturates so a disabled
    // timeout never wraps it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= 8'd0;
        end else if (w_next_state != r_state) begin
            r_wait_cnt <= 8'd0;
        end else if (w_waiting && (r_wait_cnt != 8'hFF)) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end

    // Sticky memory-error flag, only cleared by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_err <= 1'b0;
        end else if (w_set_err) begin
            r_mem_err <= 1'b1;
        end else begin
            r_mem_err <= r_mem_err;
        end
    end

    // Next-state and control decode.
    always_comb begin
        w_next_state  = r_state;
        w_set_err     = 1'b0;
        w_pc_write    = 1'b0;
        w_ir_write    = 1'b0;
        w_i_or_d      = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        w_wb_sel      = 2'b00;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_alu_ctrl_op = 2'b00;
        w_pc_source   = 1'b0;
        w_retire      = 1'b0;
        w_is_halted   = 1'b0;
        w_mem_err     = 1'b0;

        case (r_state)
            S_IF: begin
                // ALU computes PC+4 while the instruction is fetched.
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                if (mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_state = S_ID;
                end else if (w_timeout) begin
                    w_set_err    = 1'b1;
                    w_next_state = S_HALT;
                end else begin
                    w_next_state = S_IF;
                end
            end
            S_ID: begin
                // ALUOut = old_pc + imm, the branch/JAL target.
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b10;
                case (opcode)
                    OP_ECALL: begin
                        w_retire = 1'b1;
                        if (is_halt_ecall) begin
                            w_next_state = S_HALT;
                        end else begin
                            w_next_state = S_IF;
                        end
                    end
                    OP_R, OP_I, OP_LOAD, OP_STORE,
                    OP_BRANCH, OP_JAL, OP_JALR: begin
                        w_next_state = S_EX;
                    end
                    default: begin
                        // Illegal opcode retires as a NOP.
                        w_retire     = 1'b1;
                        w_next_state = S_IF;
                    end
                endcase
            end
            S_EX: begin
                case (opcode)
                    OP_R: begin
                        w_alu_src_a   = 2'b01;
                        w_alu_src_b   = 2'b00;
                        w_alu_ctrl_op = 2'b10;
                        w_next_state  = S_WB;
                    end
                    OP_I: begin
                        w_alu_src_a   = 2'b01;
                        w_alu_src_b   = 2'b10;
                        w_alu_ctrl_op = 2'b10;
                        w_next_state  = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        w_alu_src_a   = 2'b01;
                        w_alu_src_b   = 2'b10;
                        w_next_state  = S_MEM;
                    end
                    OP_BRANCH: begin
                        w_alu_src_a   = 2'b01;
                        w_alu_src_b   = 2'b00;
                        w_alu_ctrl_op = 2'b01;
                        w_pc_source   = 1'b1;
                        w_pc_write    = bcond;
                        w_retire      = 1'b1;
                        w_next_state  = S_IF;
                    end
                    OP_JAL: begin
                        // rd <= PC (already old_pc+4); PC <= ALUOut at the edge.
                        w_pc_write    = 1'b1;
                        w_pc_source   = 1'b1;
                        w_reg_write   = 1'b1;
                        w_wb_sel      = 2'b10;
                        w_retire      = 1'b1;
                        w_next_state  = S_IF;
                    end
                    OP_JALR: begin
                        w_alu_src_a   = 2'b01;
                        w_alu_src_b   = 2'b10;
                        w_pc_source   = 1'b0;
                        w_pc_write    = 1'b1;
                        w_reg_write   = 1'b1;
                        w_wb_sel      = 2'b10;
                        w_retire      = 1'b1;
                        w_next_state  = S_IF;
                    end
                    default: begin
                        w_next_state  = S_IF;
                    end
                endcase
            end
            S_MEM: begin
                w_i_or_d = 1'b1;
                if (opcode == OP_LOAD) begin
                    w_mem_read = 1'b1;
                end else begin
                    w_mem_write = 1'b1;
                end
                if (mem_ready) begin
                    if (opcode == OP_LOAD) begin
                        w_next_state = S_WB;
                    end else begin
                        w_retire     = 1'b1;
                        w_next_state = S_IF;
                    end
                end else if (w_timeout) begin
                    w_set_err    = 1'b1;
                    w_next_state = S_HALT;
                end else begin
                    w_next_state = S_MEM;
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                if (opcode == OP_LOAD) begin
                    w_wb_sel = 2'b01;
                end else begin
                    w_wb_sel = 2'b00;
                end
                w_next_state = S_IF;
            end
            S_HALT: begin
                w_is_halted  = 1'b1;
                w_mem_err    = r_mem_err;
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_IF;
            end
        endcase
    end

    // Outputs are forced low for as long as reset is held, not just after
    // the next edge.
    assign pc_write    = reset_n & w_pc_write;
    assign ir_write    = reset_n & w_ir_write;
    assign i_or_d      = reset_n & w_i_or_d;
    assign mem_read    = reset_n & w_mem_read;
    assign mem_write   = reset_n & w_mem_write;
    assign reg_write   = reset_n & w_reg_write;
    assign wb_sel      = reset_n ? w_wb_sel      : 2'b00;
    assign alu_src_a   = reset_n ? w_alu_src_a   : 2'b00;
    assign alu_src_b   = reset_n ? w_alu_src_b   : 2'b00;
    assign alu_ctrl_op = reset_n ? w_alu_ctrl_op : 2'b00;
    assign pc_source   = reset_n & w_pc_source;
    assign retire      = reset_n & w_retire;
    assign is_halted   = reset_n & w_is_halted;
    assign mem_err     = reset_n & w_mem_err;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
module tb_multi_cycle_control_unit;

    logic       clk;
    logic       reset_n;
    logic [6:0] opcode;
    logic       bcond;
    logic       is_halt_ecall;
    logic       mem_ready;
    logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
    logic [1:0] wb_sel, alu_src_a, alu_src_b, alu_ctrl_op;
    logic       pc_source, retire, is_halted, mem_err;

    multi_cycle_control_unit #(.MEM_WAIT_MAX(8)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .bcond(bcond),
        .is_halt_ecall(is_halt_ecall), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_ctrl_op(alu_ctrl_op), .pc_source(pc_source), .retire(retire),
        .is_halted(is_halted), .mem_err(mem_err)
    );

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;
    localparam logic [6:0] OP_ILL    = 7'b0000000;

    int n_checks = 0;
    int n_pass   = 0;
    int n_retire = 0;
    int retire_base;

    // Output bundle: {pcw,irw,iod,mr,mw,rw,wb[2],sa[2],sb[2],op[2],ps,ret,hlt,me}
    logic [17:0] outs;
    assign outs = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
                   wb_sel, alu_src_a, alu_src_b, alu_ctrl_op,
                   pc_source, retire, is_halted, mem_err};

    function automatic logic [17:0] mk(
        input logic pcw, input logic irw, input logic iod, input logic mr,
        input logic mw, input logic rw, input logic [1:0] wb,
        input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] op,
        input logic ps, input logic ret, input logic hlt, input logic me);
        return {pcw, irw, iod, mr, mw, rw, wb, sa, sb, op, ps, ret, hlt, me};
    endfunction

    logic [17:0] E_ZERO, E_IF_RDY, E_IF_WAIT, E_ID, E_ID_RET, E_EX_R, E_EX_I,
                 E_EX_LS, E_EX_BR0, E_EX_BR1, E_EX_JAL, E_EX_JALR, E_MEM_LD,
                 E_MEM_ST_RET, E_WB_ALU, E_WB_LD, E_HALT_OK, E_HALT_ERR;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count retire pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (retire === 1'b1) n_retire++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, check at negedge.
    task automatic cyc(input string tag, input logic [6:0] opc, input logic bc,
                       input logic ec, input logic rdy, input logic [17:0] exp);
        opcode        = opc;
        bcond         = bc;
        is_halt_ecall = ec;
        mem_ready     = rdy;
        @(negedge clk);
        check(tag, {14'd0, outs}, {14'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        check("rst_outs_zero", {14'd0, outs}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        E_ZERO       = 18'd0;
        E_IF_RDY     = mk(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0);
        E_IF_WAIT    = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0);
        E_ID         = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0);
        E_ID_RET     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b10,2'b00,1'b0,1'b1,1'b0,1'b0);
        E_EX_R       = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b00,2'b10,1'b0,1'b0,1'b0,1'b0);
        E_EX_I       = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b10,1'b0,1'b0,1'b0,1'b0);
        E_EX_LS      = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0);
        E_EX_BR0     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b00,2'b01,1'b1,1'b1,1'b0,1'b0);
        E_EX_BR1     = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b00,2'b01,1'b1,1'b1,1'b0,1'b0);
        E_EX_JAL     = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,2'b00,1'b1,1'b1,1'b0,1'b0);
        E_EX_JALR    = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b01,2'b10,2'b00,1'b0,1'b1,1'b0,1'b0);
        E_MEM_LD     = mk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0);
        E_MEM_ST_RET = mk(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0);
        E_WB_ALU     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0);
        E_WB_LD      = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0);
        E_HALT_OK    = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0);
        E_HALT_ERR   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1,1'b1);

        reset_n = 1'b0; opcode = OP_ILL; bcond = 1'b0; is_halt_ecall = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {14'd0, outs}, {14'd0, E_ZERO});
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // ADD: 4 cycles
        cyc("add_if", OP_R, 1'b0, 1'b0, 1'b1, E_IF_RDY);
        cyc("add_id", OP_R, 1'b0, 1'b0, 1'b1, E_ID);
        cyc("add_ex", OP_R, 1'b0, 1'b0, 1'b1, E_EX_R);
        cyc("add_wb", OP_R, 1'b0, 1'b0, 1'b1, E_WB_ALU);
        // ADDI
        cyc("addi_if", OP_I, 1'b0, 1'b0, 1'b1, E_IF_RDY);
        cyc("addi_id", OP_I, 1'b0, 1'b0, 1'b1, E_ID);
        cyc("addi_ex", OP_I, 1'b0, 1'b0, 1'b1, E_EX_I);
        cyc("addi_wb", OP_I, 1'b0, 1'b0, 1'b1, E_WB_ALU);
        // LOAD with 3 wait cycles in MEM: 8 cycles, one retire
        retire_base = n_retire;
        cyc("ld_if", OP_LOAD, 1'b0, 1'b0, 1'b1, E_IF_RDY);
        cyc("ld_id", OP_LOAD, 1'b0, 1'b0, 1'b1, E_ID);
        cyc("ld_ex", OP_LOAD, 1'b0, 1'b0, 1'b1, E_EX_LS);
        for (int i = 0; i < 3; i++) cyc("ld_mem_wait", OP_LOAD, 1'b0, 1'b0, 1'b0, E_MEM_LD);
        cyc("ld_mem_done", OP_LOAD, 1'b0, 1'b0, 1'b1, E_MEM_LD);
        cyc("ld_wb", OP_LOAD, 1'b0, 1'b0, 1'b1, E_WB_LD);
        check("ld_retire_count", n_retire - retire_base, 32'd1);
        // STORE: 4 cycles
        cyc("st_if", OP_STORE, 1'b0, 1'b0, 1'b1, E_IF_RDY);
        cyc("st_id", OP_STORE, 1'b0, 1'b0, 1'b1, E_ID);
        cyc("st_ex", OP_STORE, 1'b0, 1'b0, 1'b1, E_EX_LS);
        cyc("st_mem", OP_STORE, 1'b0, 1'b0, 1'b1, E_MEM_ST_RET);
        // BRANCH not taken / taken
        cyc("br0_if", OP_BRANCH, 1'b0, 1'b0, 1'b1, E_IF_RDY);
        cyc("br0_id", OP_BRANCH, 1'b0, 1'b0, 1'b1, E_ID);
        cyc("br0_ex", OP_BRANCH, 1'b0, 1'b0, 1'b1, E_EX_BR0);
        cyc("br1_if", OP_BRANCH, 1'b1, 1'b0, 1'b1, E_IF_RDY);
        cyc("br1_id", OP_BRANCH, 1'b1, 1'b0, 1'b1, E_ID);
        cyc("br1_ex", OP_BRANCH, 1'b1, 1'b0, 1'b1, E_EX_BR1);
        // JAL, JALR
        cyc("jal_if", OP_JAL, 1'b0, 1'b0, 1'b1, E_IF_RDY);
        cyc("jal_id", OP_JAL, 1'b0, 1'b0, 1'b1, E_ID);
        cyc("jal_ex", OP_JAL, 1'b0, 1'b0, 1'b1, E_EX_JAL);
        cyc("jalr_if", OP_JALR, 1'b0, 1'b0, 1'b1, E_IF_RDY);
        cyc("jalr_id", OP_JALR, 1'b0, 1'b0, 1'b1, E_ID);
        cyc("jalr_ex", OP_JALR, 1'b0, 1'b0, 1'b1, E_EX_JALR);
        // Illegal opcode and non-halting ECALL retire in ID
        cyc("ill_if", OP_ILL, 1'b0, 1'b0, 1'b1, E_IF_RDY);
        cyc("ill_id", OP_ILL, 1'b0, 1'b0, 1'b1, E_ID_RET);
        cyc("ecall0_if", OP_ECALL, 1'b0, 1'b0, 1'b1, E_IF_RDY);
        cyc("ecall0_id", OP_ECALL, 1'b0, 1'b0, 1'b1, E_ID_RET);
        // Fetch completing exactly at the wait limit is not a timeout
        for (int i = 0; i < 8; i++) cyc("lim_if_wait", OP_LOAD, 1'b0, 1'b0, 1'b0, E_IF_WAIT);
        cyc("lim_if_rdy", OP_LOAD, 1'b0, 1'b0, 1'b1, E_IF_RDY);
        cyc("lim_id", OP_LOAD, 1'b0, 1'b0, 1'b1, E_ID);
        cyc("lim_ex", OP_LOAD, 1'b0, 1'b0, 1'b1, E_EX_LS);

        // Reset asserted mid-MEM: outputs drop without waiting for an edge
        opcode = OP_LOAD; mem_ready = 1'b0;
        #2;
        check("mem_before_rst", {14'd0, outs}, {14'd0, E_MEM_LD});
        reset_n = 1'b0;
        #1;
        check("rst_async_zero", {14'd0, outs}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc("post_rst_if", OP_LOAD, 1'b0, 1'b0, 1'b0, E_IF_WAIT);

        // ECALL halt
        cyc("ecall1_if", OP_ECALL, 1'b0, 1'b1, 1'b1, E_IF_RDY);
        cyc("ecall1_id", OP_ECALL, 1'b0, 1'b1, 1'b1, E_ID_RET);
        cyc("ecall_halt", OP_ECALL, 1'b0, 1'b1, 1'b1, E_HALT_OK);
        cyc("ecall_halt_hold", OP_R, 1'b0, 1'b0, 1'b1, E_HALT_OK);

        // Fetch timeout: 9 waiting IF cycles, then HALT with mem_err
        do_reset();
        for (int i = 0; i < 9; i++) cyc("to_if_wait", OP_R, 1'b0, 1'b0, 1'b0, E_IF_WAIT);
        cyc("to_halt", OP_R, 1'b0, 1'b0, 1'b0, E_HALT_ERR);
        cyc("to_halt_hold", OP_R, 1'b0, 1'b0, 1'b1, E_HALT_ERR);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/multi_cycle_control_unit.md
Name: multi_cycle_control_unit

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences the shared ALU, memory port, IR/PC and register-file write through the IF/ID/EX/MEM/WB steps.
- Drives the ALU operand muxes and a 2-bit ALU-op class to alu_control_unit, which decodes funct3/funct7 from the IR.
- Handles memory wait states, ECALL halt and illegal opcodes.

Parameters:
MEM_WAIT_MAX, 8, max cycles to wait for mem_ready in IF/MEM before a memory-error halt; 0 disables the timeout.

Ports:
clk  input  1  core clock, rising edge
reset_n  input  1  asynchronous active-low reset
opcode  input  7  IR[6:0], valid from ID onward
bcond  input  1  branch condition from ALU, valid in EX for BRANCH
is_halt_ecall  input  1  1 when x17==10, sampled in ID for ECALL
mem_ready  input  1  memory access completes this cycle
pc_write  output  1  PC load enable
ir_write  output  1  IR + old_pc load enable
i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
reg_write  output  1  register-file write enable
wb_sel  output  2  rd data select: 00=ALUOut, 01=MDR, 10=PC
alu_src_a  output  2  00=PC, 01=A(rs1), 10=old_pc
alu_src_b  output  2  00=B(rs2), 01=const 4, 10=imm
alu_ctrl_op  output  2  00=ADD, 01=branch compare (funct3), 10=funct decode
pc_source  output  1  0=ALU result, 1=ALUOut
retire  output  1  one-cycle pulse when an instruction completes
is_halted  output  1  high in HALT
mem_err  output  1  high in HALT if entered by timeout

Behaviour:
- State register, 3 bits: IF, ID, EX, MEM, WB, HALT.
- Wait counter: 8 bits.
- Outputs are combinational from state, opcode, bcond and mem_ready. Any output not listed for a state is 0; muxes default to 00 / 0.
- Reset: reset_n low asynchronously forces state=IF, wait counter=0 and mem_err flag=0. All outputs are 0 while reset_n=0. The first IF cycle follows release.
- IF:
  - Drive mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_ctrl_op=00.
  - If mem_ready: also drive ir_write=1, pc_write=1, pc_source=0, then go to ID. Otherwise stay in IF and increment the wait counter.
- ID:
  - Drive alu_src_a=10, alu_src_b=10, alu_ctrl_op=00, so ALUOut = old_pc + imm.
  - ECALL (1110011): if is_halt_ecall, go to HALT with retire=1. Otherwise go to IF with retire=1.
  - Unknown opcode: illegal, treated as NOP; go to IF with retire=1.
  - Otherwise go to EX.
- EX, by opcode:
  - R-type 0110011: src_a=01, src_b=00, op=10, then WB.
  - I-arith 0010011: src_a=01, src_b=10, op=10, then WB.
  - LOAD 0000011 / STORE 0100011: src_a=01, src_b=10, op=00, then MEM.
  - BRANCH 1100011: src_a=01, src_b=00, op=01, pc_source=1, pc_write=bcond, retire=1, then IF.
  - JAL 1101111: pc_write=1, pc_source=1, reg_write=1, wb_sel=10, retire=1, then IF.
  - JALR 1100111: src_a=01, src_b=10, op=00, pc_source=0, pc_write=1, reg_write=1, wb_sel=10, retire=1, then IF.
  - In JAL/JALR, PC still holds old_pc+4 when rd is written; the PC update lands at the clock edge.
- MEM:
  - Drive i_or_d=1, with mem_read=1 for LOAD or mem_write=1 for STORE.
  - On mem_ready: LOAD goes to WB; STORE goes to IF with retire=1.
  - Otherwise stay in MEM and count wait cycles.
- WB: reg_write=1, retire=1. wb_sel=01 for LOAD, otherwise 00. Then go to IF.
- Wait counter:
  - Cleared on every state change.
  - If MEM_WAIT_MAX!=0 and the counter reaches MEM_WAIT_MAX with mem_ready still 0, go to HALT and set the mem_err flag.
  - mem_ready in the same cycle as the limit takes priority; the access completes normally.
- HALT: absorbing until reset. is_halted=1, mem_err = flag, all other outputs 0.
- Retire occurs exactly once per instruction.
- CPI with zero-wait memory: R/I=4, LOAD=5, STORE=4, BRANCH/JAL/JALR=3, ECALL=2.

Test Plan:
- Reset mid-MEM: assert reset_n=0 during a LOAD in MEM with mem_read=1 -> all outputs 0 immediately, not at the next edge; after release the next cycle is IF with mem_read=1, i_or_d=0.
- ADD, opcode 0110011, mem_ready always 1 -> states IF,ID,EX,WB; EX shows src_a=01, src_b=00, op=10; WB shows reg_write=1, wb_sel=00, retire=1; exactly 4 cycles.
- LOAD with mem_ready held low for 3 MEM cycles -> MEM lasts 4 cycles; WB shows wb_sel=01; total 8 cycles; one retire pulse.
- BRANCH with bcond=0, then with bcond=1 -> in EX, pc_write=0 then 1, pc_source=1 in both, retire=1 in both; 3 cycles each.
- JAL, then JALR -> JAL EX: pc_source=1, wb_sel=10, reg_write=1. JALR EX: src_a=01, src_b=10, pc_source=0.
- ECALL with is_halt_ecall=1 -> HALT after ID; is_halted=1, mem_err=0.
- Fetch timeout with MEM_WAIT_MAX=8 and mem_ready=0 -> HALT with mem_err=1 after the limit.
- Illegal opcode 0000000 -> returns to IF after ID with one retire pulse.
